apb_master: RTL and testbench

APB requester that drives the APB bus toward the on-chip APB completer (RAM) from a simple command/response handshake. A client issues one read or write command. The block sequences SETUP and ACCESS phases, waits for pready, captures prdata and pslverr, and returns one response per command. A wait-state timeout keeps a hung completer from stalling the client.

---
 rtl/apb_master_if.sv | 37 +++
 rtl/apb_master.sv | 127 ++++++++++++
 tb/tb_apb_master.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/apb_master_if.sv
// Command/response handshake plus APB bus signals of the APB requester.
// master is the requester's view; slave is the view of the client and completer around it.
interface apb_master_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              rsp_timeout;
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic [DATA_W-1:0] prdata;
   logic              pready;
   logic              pslverr;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready, pslverr,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
             psel, penable, pwrite, paddr, pwdata
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready, pslverr,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
             psel, penable, pwrite, paddr, pwdata
   );
endinterface

// File: rtl/apb_master.sv
// APB requester: one command in, SETUP/ACCESS on the bus, one response out.
// ACCESS is aborted with a timeout response after TIMEOUT cycles with pready low.
module apb_master #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic          pclk,
   input  logic          presetn,
   apb_master_if.master  bus
);
   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

   state_e            state_q, state_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic              pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic              rsp_timeout_q, rsp_timeout_d;
   logic [CntW-1:0]   cnt_q, cnt_d;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q       <= StIdle;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
         cnt_q         <= cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      psel_d        = psel_q;
      penable_d     = penable_q;
      pwrite_d      = pwrite_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;
      cnt_d         = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (bus.cmd_valid) begin
               pwrite_d  = bus.cmd_write;
               paddr_d   = bus.cmd_addr;
               pwdata_d  = bus.cmd_wdata;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               state_d   = StSetup;
            end
         end
         StSetup: begin
            penable_d = 1'b1;
            cnt_d     = '0;
            state_d   = StAccess;
         end
         StAccess: begin
            // pready wins over the timeout in the last allowed cycle
            if (bus.pready) begin
               rsp_rdata_d   = (pwrite_q || bus.pslverr) ? '0 : bus.prdata;
               rsp_err_d     = bus.pslverr;
               rsp_timeout_d = 1'b0;
               rsp_valid_d   = 1'b1;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               state_d       = StResp;
            end else if (cnt_q == CntMax) begin
               rsp_rdata_d   = '0;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               rsp_valid_d   = 1'b1;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               state_d       = StResp;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StResp: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.cmd_ready   = (state_q == StIdle);
   assign bus.psel        = psel_q;
   assign bus.penable     = penable_q;
   assign bus.pwrite      = pwrite_q;
   assign bus.paddr       = paddr_q;
   assign bus.pwdata      = pwdata_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_rdata   = rsp_rdata_q;
   assign bus.rsp_err     = rsp_err_q;
   assign bus.rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed and random transfers against a RAM completer,
// with expected responses taken from a transaction-level model.
module tb_apb_master;
   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned TIMEOUT = 4;

   logic pclk;
   logic presetn;
   int   errors;
   int   checks;

   logic [31:0] comp_mem [0:63];
   logic [31:0] ref_mem  [0:63];

   apb_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   apb_master #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .pclk   (pclk),
      .presetn(presetn),
      .bus    (bus)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // waits = ACCESS cycles with pready low before the completer answers; >= TIMEOUT means never
   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input int waits, input logic err, input int rsp_delay);
      int          k;
      logic        tmo;
      int          acc_exp;
      logic [31:0] rdata_exp;
      logic        err_exp;
      int          idx;
      idx       = int'(addr[5:0]);
      tmo       = (waits >= int'(TIMEOUT));
      acc_exp   = tmo ? int'(TIMEOUT) : waits + 1;
      err_exp   = tmo || err;
      rdata_exp = (tmo || err || wr) ? 32'h0 : ref_mem[idx];
      if (wr && !err && !tmo) ref_mem[idx] = wdata;

      @(negedge pclk);
      chk("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = wdata;
      @(posedge pclk);
      @(negedge pclk);
      chk("setup_psel_penable", {62'd0, bus.psel, bus.penable}, 64'd2);
      chk("setup_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      bus.cmd_valid = 1'b0;
      // pready high in SETUP must be ignored
      bus.pready  = 1'b1;
      bus.pslverr = 1'(($urandom & 1));
      bus.prdata  = $urandom;
      @(posedge pclk);
      @(negedge pclk);
      k = 0;
      while (bus.psel && bus.penable && k < int'(TIMEOUT) + 4) begin
         k++;
         chk("access_addr", 64'(bus.paddr), 64'(addr));
         chk("access_dir_data", {31'd0, bus.pwrite, bus.pwdata}, {31'd0, wr, wdata});
         bus.pready = (k == waits + 1);
         if (bus.pready) begin
            bus.pslverr = err;
            bus.prdata  = (!wr && !err) ? comp_mem[idx] : $urandom;
            if (wr && !err) comp_mem[idx] = wdata;
         end else begin
            bus.pslverr = 1'(($urandom & 1));
            bus.prdata  = $urandom;
         end
         @(posedge pclk);
         @(negedge pclk);
      end
      bus.pready  = 1'b0;
      bus.pslverr = 1'b0;
      chk("access_cycles", 64'(k), 64'(acc_exp));
      chk("bus_released", {62'd0, bus.psel, bus.penable}, 64'd0);
      chk("rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata},
          {1'b1, err_exp, tmo, rdata_exp});
      for (int d = 0; d < rsp_delay; d++) begin
         bus.rsp_ready = 1'b0;
         bus.cmd_valid = 1'b1;
         bus.cmd_write = 1'(($urandom & 1));
         bus.cmd_addr  = $urandom;
         @(posedge pclk);
         @(negedge pclk);
         chk("rsp_hold", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata},
             {1'b1, err_exp, tmo, rdata_exp});
         chk("rsp_wait_blocked", {62'd0, bus.cmd_ready, bus.psel}, 64'd0);
      end
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(posedge pclk);
      @(negedge pclk);
      bus.rsp_ready = 1'b0;
      chk("rsp_done", {61'd0, bus.rsp_valid, bus.cmd_ready, bus.psel}, 64'd2);
      chk("rsp_fields_kept", {bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata},
          {err_exp, tmo, rdata_exp});
   endtask

   initial begin
      errors        = 0;
      checks        = 0;
      presetn       = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.rsp_ready = 1'b0;
      bus.prdata    = '0;
      bus.pready    = 1'b0;
      bus.pslverr   = 1'b0;
      for (int i = 0; i < 64; i++) begin
         comp_mem[i] = 32'h0;
         ref_mem[i]  = 32'h0;
      end

      repeat (2) @(negedge pclk);
      chk("reset_bus", {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata}, '0);
      chk("reset_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata}, '0);
      chk("reset_cmd_ready", 64'(bus.cmd_ready), 64'd1);
      presetn = 1'b1;

      // Directed steps
      xfer(1'b1, 32'h5, 32'hDEAD_BEEF, 0, 1'b0, 0);
      xfer(1'b0, 32'h5, 32'h0, 3, 1'b0, 0);
      xfer(1'b0, 32'h40, 32'h0, 0, 1'b1, 1);
      xfer(1'b0, 32'h5, 32'h0, 100, 1'b0, 0);
      xfer(1'b1, 32'h7, 32'h1234_5678, 3, 1'b0, 0);
      xfer(1'b0, 32'h7, 32'h0, 0, 1'b0, 5);

      // Reset during ACCESS
      @(negedge pclk);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 32'h5;
      @(posedge pclk);
      @(negedge pclk);
      bus.cmd_valid = 1'b0;
      bus.pready    = 1'b0;
      @(posedge pclk);
      @(negedge pclk);
      chk("pre_reset_access", {62'd0, bus.psel, bus.penable}, 64'd3);
      #2 presetn = 1'b0;
      #1;
      chk("async_reset_drop", {61'd0, bus.psel, bus.penable, bus.rsp_valid}, 64'd0);
      @(negedge pclk);
      presetn = 1'b1;
      repeat (2) @(posedge pclk);
      @(negedge pclk);
      chk("post_reset_idle", {61'd0, bus.cmd_ready, bus.rsp_valid, bus.psel}, 64'd4);

      // Random transfers
      for (int n = 0; n < 40; n++) begin
         xfer(1'(($urandom & 1)), 32'($urandom_range(0, 63)), $urandom,
              int'($urandom_range(0, 5)), ($urandom_range(0, 7) == 0),
              int'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
